// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; fetch is forced through after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic [1:0]  proc2mem_cmd,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_data,
  input  logic [31:0] mem2proc_data,
  input  logic        mem2proc_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q, sel_addr;
  logic        we_q;
  logic [3:0]  starve_cnt;
  logic        starve_hit;

  assign starve_hit = (starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dm_req && !(if_req && starve_hit)) state_nx = DATA;
        else if (if_req)                       state_nx = FETCH;
      end
      FETCH, DATA: begin
        if (mem2proc_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Word-align by masking so every address bit is consumed.
  assign sel_addr = ((state_nx == FETCH) ? if_addr : dm_addr) & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) begin
        addr_q  <= sel_addr;
        we_q    <= dm_we;
        wdata_q <= dm_wdata;
      end
      if (if_done)
        starve_cnt <= '0;
      else if (dm_done && if_req && !starve_hit)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    if_done      = 1'b0;
    dm_done      = 1'b0;
    if_rdata     = '0;
    dm_rdata     = '0;
    proc2mem_cmd = 2'b00;
    case (state)
      FETCH: begin
        proc2mem_cmd = 2'b01;
        if (mem2proc_ready) begin
          if_done  = 1'b1;
          if_rdata = mem2proc_data;
        end
      end
      DATA: begin
        proc2mem_cmd = we_q ? 2'b10 : 2'b01;
        if (mem2proc_ready) begin
          dm_done = 1'b1;
          if (!we_q) dm_rdata = mem2proc_data;
        end
      end
      default: ;
    endcase
  end

  assign proc2mem_addr = addr_q;
  assign proc2mem_data = wdata_q;

  // Stalls are also forced low during reset so every output reads 0 while rst is high.
  assign if_stall = if_req & ~if_done & ~rst;
  assign dm_stall = dm_req & ~dm_done & ~rst;

endmodule
